// File: rtl/rsp_fifo_sync_pkg.sv
// ---------------------------------------------------------------------------
// rsp_fifo_pkg
// Shared helpers for the response FIFO: a clog2 function, width helpers for
// the address and level fields, and a legality check on the parameter set.
// Widths depend on each instance's DEPTH, so they are provided as constant
// functions. Modules turn them into their own localparams.
// ---------------------------------------------------------------------------
package rsp_fifo_pkg;

  localparam int DEFAULT_DATA_W = 128;
  localparam int DEFAULT_DEPTH  = 16;

  // Ceiling log2. For values of 1 or less the result is 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // The address field indexes the storage array.
  function automatic int addr_w(input int depth);
    return clog2(depth);
  endfunction

  // Pointers and the level carry one more bit than the address. The level
  // must hold the values 0 through DEPTH.
  function automatic int level_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  // Wrap-bit pointer arithmetic is only correct for a power-of-two depth.
  function automatic bit params_ok(input int depth, input int afull_thr);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (afull_thr >= 1) && (afull_thr <= depth);
  endfunction

endpackage

// File: rtl/rsp_fifo_sync_if.sv
// ---------------------------------------------------------------------------
// rsp_fifo_sync_if
// Bundles the producer-side and consumer-side handshakes of the response
// FIFO, together with its status outputs.
//   io_push_valid / io_push_ready / io_push_rsp_data : producer side
//   io_pop_valid  / io_pop_ready  / io_pop_rsp_data  : consumer side (show-ahead)
//   io_level       : current entry count, 0..DEPTH
//   io_almost_full : io_level >= AFULL_THR
// The slave modport is the FIFO. The master modport is the combined
// producer and consumer environment.
// ---------------------------------------------------------------------------
interface rsp_fifo_sync_if
  import rsp_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
);

  logic                        io_push_valid;
  logic                        io_push_ready;
  logic [DATA_W-1:0]           io_push_rsp_data;
  logic                        io_pop_valid;
  logic                        io_pop_ready;
  logic [DATA_W-1:0]           io_pop_rsp_data;
  logic [level_w(DEPTH)-1:0]   io_level;
  logic                        io_almost_full;

  modport slave (
    input  io_push_valid, io_push_rsp_data, io_pop_ready,
    output io_push_ready, io_pop_valid, io_pop_rsp_data, io_level, io_almost_full
  );

  modport master (
    output io_push_valid, io_push_rsp_data, io_pop_ready,
    input  io_push_ready, io_pop_valid, io_pop_rsp_data, io_level, io_almost_full
  );

endinterface

// File: rtl/rsp_fifo_sync_ram.sv
// ---------------------------------------------------------------------------
// rsp_fifo_ram
// DEPTH x DATA_W storage array. It has one synchronous write port and one
// asynchronous read port. The array has no reset, so it can map onto
// distributed RAM or a plain register file.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
// ---------------------------------------------------------------------------
module rsp_fifo_ram
  import rsp_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rsp_fifo_sync.sv
// ---------------------------------------------------------------------------
// rsp_fifo_sync
// Single-clock, show-ahead response FIFO with a parametrised width and depth.
// It also reports the fill level and an almost-full flag.
//   clk  : sole clock, rising edge
//   rstn : asynchronous active-low reset; clears both pointers
//   bus  : rsp_fifo_sync_if.slave (push and pop handshakes, level, almost full)
// Optional feature, macro RSP_FIFO_BYPASS_EN: when the FIFO is empty, a
// producer beat is shown directly on the pop side. If the consumer takes the
// beat in that same cycle, the beat is never written into storage.
// ---------------------------------------------------------------------------
module rsp_fifo_sync
  import rsp_fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AFULL_THR = DEPTH - 2
) (
  input  logic            clk,
  input  logic            rstn,
  rsp_fifo_sync_if.slave  bus
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int LVL_W  = level_w(DEPTH);

  if (!params_ok(DEPTH, AFULL_THR)) begin : g_param_check
    $error("rsp_fifo_sync: DEPTH must be a power of two >= 2 and AFULL_THR within 1..DEPTH");
  end

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic              empty;
  logic              push_fire;
  logic              pop_fire;
  logic              wr_en;
  logic              rd_adv;
  logic [DATA_W-1:0] ram_rdata;

  // The MSB of each pointer is a wrap bit. Equal addresses with different
  // wrap bits mean the writer is a full lap ahead of the reader.
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;

  // push_ready depends only on registered state. A full FIFO therefore
  // refuses a push even when a pop happens in the same cycle.
  assign bus.io_push_ready  = !full;
  assign bus.io_level       = level;
  assign bus.io_almost_full = (level >= LVL_W'(AFULL_THR));

  assign push_fire = bus.io_push_valid & bus.io_push_ready;
  assign pop_fire  = bus.io_pop_valid & bus.io_pop_ready;

`ifdef RSP_FIFO_BYPASS_EN
  logic bypass;

  // Empty FIFO with a beat offered: hand the beat straight to the consumer.
  // The write is suppressed only when the consumer takes the beat now.
  // The read pointer only advances for beats that were actually stored.
  assign bypass              = empty & bus.io_push_valid;
  assign bus.io_pop_valid    = !empty | bus.io_push_valid;
  assign bus.io_pop_rsp_data = empty ? bus.io_push_rsp_data : ram_rdata;
  assign wr_en               = push_fire & !(bypass & bus.io_pop_ready);
  assign rd_adv              = pop_fire & !empty;
`else
  assign bus.io_pop_valid    = !empty;
  assign bus.io_pop_rsp_data = ram_rdata;
  assign wr_en               = push_fire;
  assign rd_adv              = pop_fire;
`endif

  // The pointers wrap naturally at 2*DEPTH. The level is their difference,
  // so no separate counter is kept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + (ADDR_W + 1)'(1);
      end
    end
  end

  rsp_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.io_push_rsp_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

endmodule
